// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline sequencing controller
package pipe_pkg;
  typedef enum logic [1:0] {RUN, FREEZE, HALT} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
  } ctrl_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);
  // count up on inc, hold at all-ones
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubbles, branch squashes, memory freezes and timeout watchdog
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout,
  output logic             halted
);
  localparam int FW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] LAST = FW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_t        state;
  logic [FW-1:0] freeze_cnt;
  logic          load_use;
  ctrl_t         c;

  assign load_use = idex_mem_read && idex_rt != REG_ZERO &&
                    (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));

  // priority: halt/reset, freeze, branch squash, load-use bubble, normal flow
  always_comb
    c = (reset || state == HALT || mem_busy) ? ctrl_t'(6'b000000) :
        branch_taken ? ctrl_t'(6'b111111) :
        load_use     ? ctrl_t'(6'b000111) : ctrl_t'(6'b110101);

  assign pc_en      = c.pc_en;
  assign ifid_en    = c.ifid_en;
  assign ifid_flush = c.ifid_flush;
  assign idex_en    = c.idex_en;
  assign idex_flush = c.idex_flush;
  assign exmem_en   = c.exmem_en;

  // sequencing FSM with consecutive-busy watchdog; HALT exits only via reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= RUN;
      freeze_cnt  <= '0;
      mem_timeout <= 1'b0;
      halted      <= 1'b0;
    end else if (state != HALT) begin
      if (!mem_busy) begin
        state      <= RUN;
        freeze_cnt <= '0;
      end else if (TIMEOUT != 0 && freeze_cnt == LAST) begin
        state       <= HALT;
        halted      <= 1'b1;
        mem_timeout <= 1'b1;
      end else begin
        state      <= FREEZE;
        freeze_cnt <= freeze_cnt + FW'(1);
      end
    end

  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .reset(reset), .clear(1'b0),
    .inc(state != HALT && (mem_busy || (!branch_taken && load_use))),
    .count(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .reset(reset), .clear(1'b0),
    .inc(state != HALT && !mem_busy && branch_taken),
    .count(flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (CNT_W=3, TIMEOUT=4)
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic ifid_uses_rt, idex_mem_read, branch_taken, mem_busy;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic [2:0] stall_cnt, flush_cnt;
  logic mem_timeout, halted;

  hazard_ctrl #(.CNT_W(3), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] c;
    int         st;
    int         fl;
    logic       h;
    logic       t;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int m_st, m_fl, m_fc;
  logic m_halt, m_to;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ctrl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}, 6'b0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_timeout", mem_timeout, 0);
    @(negedge clk);
    reset = 1'b0;
    m_st = 0; m_fl = 0; m_fc = 0; m_halt = 1'b0; m_to = 1'b0;
  endtask

  task automatic step(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                      input logic [4:0] rtt, input logic urt, input logic br, input logic busy);
    exp_t e, g;
    logic lu;
    idex_mem_read = mr; idex_rt = rt; ifid_rs = rs; ifid_rt = rtt;
    ifid_uses_rt = urt; branch_taken = br; mem_busy = busy;
    lu = mr && rt != 5'd0 && (rt == rs || (urt && rt == rtt));
    e.c  = (m_halt || busy) ? 6'b000000 : br ? 6'b111111 : lu ? 6'b000111 : 6'b110101;
    e.st = m_st; e.fl = m_fl; e.h = m_halt; e.t = m_to;
    q.push_back(e);
    #4;
    g = q.pop_front();
    chk("ctrl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}, g.c);
    chk("stall_cnt", stall_cnt, g.st);
    chk("flush_cnt", flush_cnt, g.fl);
    chk("halted", halted, g.h);
    chk("mem_timeout", mem_timeout, g.t);
    @(posedge clk);
    if (!m_halt) begin
      if (busy || (!br && lu)) m_st = (m_st < 7) ? m_st + 1 : 7;
      if (!busy && br) m_fl = (m_fl < 7) ? m_fl + 1 : 7;
      if (!busy) m_fc = 0;
      else if (m_fc == 3) begin m_halt = 1'b1; m_to = 1'b1; end
      else m_fc++;
    end
    @(negedge clk);
  endtask

  initial begin
    {idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, branch_taken, mem_busy} = '0;
    do_reset();
    step(1, 5, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 7, 1, 7, 1, 0, 0);
    step(1, 7, 1, 7, 0, 0, 0);
    step(1, 5, 5, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 5, 5, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 5, 5, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 9, 3, 9, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
